wc_2_3_tile_feeder: RTL

//   Input stage directly upstream of the WC_2_3 Winograd F(2,3) core.

---
 rtl/wc_2_3_tile_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wc_2_3_tile_feeder.sv
// Input stage for the WC_2_3 Winograd F(2,3) core: loads taps g0..g2, then slides a
// 4-sample, stride-2 window over each frame and hands tiles out on a valid/ready link.
module wc_2_3_tile_feeder #(
    parameter int DW        = 10,
    parameter int FRAME_LEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sof,
    input  logic [DW-1:0]   in_data,
    output logic [3*DW-1:0] g_out,
    output logic            g_valid,
    output logic            tile_valid,
    input  logic            tile_ready,
    output logic [4*DW-1:0] tile_data,
    output logic            tile_last,
    output logic            frame_err
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FIRST_CNT = CW'(4);

    typedef enum logic [1:0] {IDLE, LOAD_G, FILL, STREAM} state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     g_reg   [3];
    logic [DW-1:0]     win_reg [4];
    logic              g_idx_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_inc;
    logic [4*DW-1:0]   tile_data_reg;
    logic              tile_valid_reg;
    logic              tile_last_reg;
    logic              g_valid_reg;
    logic              frame_err_reg;

    logic accept;
    logic tile_take;
    logic abort;
    logic all_in;

    assign accept    = in_valid && in_ready;
    assign tile_take = tile_valid_reg && tile_ready;
    assign abort     = accept && in_sof && (state_reg != IDLE);
    assign all_in    = (cnt_reg == LAST_CNT);
    assign cnt_inc   = cnt_reg + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = LOAD_G;
        end else begin
            case (state_reg)
                IDLE:    if (accept && in_sof) state_next = LOAD_G;
                LOAD_G:  if (accept && g_idx_reg) state_next = FILL;
                FILL:    if (accept && (cnt_inc == FIRST_CNT)) state_next = STREAM;
                STREAM:  if (all_in && tile_take) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: once the whole frame is in, hold input until the final tile leaves
    always_comb begin
        in_ready = 1'b1;
        case (state_reg)
            FILL:    in_ready = !(tile_valid_reg && !tile_ready);
            STREAM:  in_ready = all_in ? 1'b0 : !(tile_valid_reg && !tile_ready);
            default: in_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) g_reg[i] <= '0;
            for (int i = 0; i < 4; i++) win_reg[i] <= '0;
            g_idx_reg      <= 1'b0;
            cnt_reg        <= '0;
            tile_data_reg  <= '0;
            tile_valid_reg <= 1'b0;
            tile_last_reg  <= 1'b0;
            g_valid_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (tile_take) begin
                tile_valid_reg <= 1'b0;
                tile_last_reg  <= 1'b0;
            end
            if (accept && in_sof) begin
                g_reg[0]    <= in_data;
                g_valid_reg <= 1'b0;
                g_idx_reg   <= 1'b0;
                cnt_reg     <= '0;
                if (state_reg != IDLE) begin
                    frame_err_reg  <= 1'b1;
                    tile_valid_reg <= 1'b0;
                    tile_last_reg  <= 1'b0;
                end
            end else if (accept) begin
                case (state_reg)
                    LOAD_G: begin
                        if (!g_idx_reg) begin
                            g_reg[1] <= in_data;
                        end else begin
                            g_reg[2]    <= in_data;
                            g_valid_reg <= 1'b1;
                        end
                        g_idx_reg <= ~g_idx_reg;
                    end
                    FILL, STREAM: begin
                        win_reg[0] <= win_reg[1];
                        win_reg[1] <= win_reg[2];
                        win_reg[2] <= win_reg[3];
                        win_reg[3] <= in_data;
                        cnt_reg    <= cnt_inc;
                        // A tile completes on every even sample count from 4 onward
                        if ((cnt_inc >= FIRST_CNT) && !cnt_inc[0]) begin
                            tile_data_reg  <= {in_data, win_reg[3], win_reg[2], win_reg[1]};
                            tile_valid_reg <= 1'b1;
                            tile_last_reg  <= (cnt_inc == LAST_CNT);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pack
            assign g_out[gi*DW +: DW] = g_reg[gi];
        end
    endgenerate

    assign g_valid    = g_valid_reg;
    assign tile_valid = tile_valid_reg;
    assign tile_data  = tile_data_reg;
    assign tile_last  = tile_last_reg;
    assign frame_err  = frame_err_reg;

endmodule
